// File: rtl/intr_edge_arb_pkg.sv
// Shared types and helpers for the edge-triggered interrupt arbiter.
// Index 0 is the highest-priority line (PI level 1).
package ks10_intr_pkg;

  localparam int NREQ_DEF = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Lowest set index among the first n bits of v; 0 when none are set.
  function automatic int prio_enc(input logic [31:0] v, input int n);
    int  idx;
    bit  found;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k < n && v[k] && !found) begin
        idx   = k;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_edge_arb_if.sv
// Request-side inputs and CPU-side handshake of the interrupt arbiter.
// slave = arbiter view, master = device/CPU view.
interface intr_edge_arb_if #(
  parameter int NREQ = 7,
  parameter int IW   = 3
);
  logic            clken;
  logic [NREQ-1:0] pol;
  logic [NREQ-1:0] enable;
  logic [NREQ-1:0] req_in;
  logic [NREQ-1:0] clr;
  logic            irq_ack;
  logic            irq;
  logic [IW-1:0]   irq_num;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] ovf;

  modport slave (
    input  clken, pol, enable, req_in, clr, irq_ack,
    output irq, irq_num, pend, ovf
  );

  modport master (
    output clken, pol, enable, req_in, clr, irq_ack,
    input  irq, irq_num, pend, ovf
  );
endinterface

// File: rtl/intr_edge_arb_edge_capture.sv
// Per-line edge detector: holds the last sampled level and flags an
// enabled edge of the selected polarity on clock-enabled cycles.
module edge_capture (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic pol,
  input  logic i,
  input  logic en,
  output logic o_set
);
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last <= 1'b0;
    else if (clken) last <= i;
  end

  assign o_set = en & clken & (pol ? (i & ~last) : (~i & last));
endmodule

// File: rtl/intr_edge_arb.sv
// Edge-triggered interrupt arbiter: captures per-line events into pend/ovf,
// grants the highest-priority eligible line and holds it over a req/ack handshake.
module intr_edge_arb
  import ks10_intr_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = 3
) (
  input logic           clk,
  input logic           rst,
  intr_edge_arb_if.slave bus
);
  state_e          state_q, state_d;
  logic [IW-1:0]   irq_num_q, irq_num_d, winner;
  logic [NREQ-1:0] set_v, elig, ack_clr, clr_all, pend_q, ovf_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    edge_capture u_cap (
      .clk   (clk),
      .rst   (rst),
      .clken (bus.clken),
      .pol   (bus.pol[g]),
      .i     (bus.req_in[g]),
      .en    (bus.enable[g]),
      .o_set (set_v[g])
    );
  end

  assign elig    = pend_q & bus.enable;
  assign winner  = IW'(prio_enc(32'(elig), NREQ));
  assign clr_all = bus.clr | ack_clr;

  always_comb begin
    ack_clr = '0;
    if (state_q == ASSERT && bus.irq_ack) ack_clr[irq_num_q] = 1'b1;
  end

  // A new event always wins over any clear, so set is OR'd in last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= set_v | (pend_q & ~clr_all);
      ovf_q  <= (set_v & pend_q & ~clr_all) | (ovf_q & ~(bus.clr & ~set_v));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_num_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_num_q <= irq_num_d;
    end
  end

  // RELEASE re-arbitrates from the post-ack snapshot so irq drops for one cycle only.
  always_comb begin
    state_d   = state_q;
    irq_num_d = irq_num_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          irq_num_d = winner;
          state_d   = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.irq_ack || !elig[irq_num_q]) state_d = RELEASE;
      end
      RELEASE: begin
        if (|elig) begin
          irq_num_d = winner;
          state_d   = ASSERT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.irq     = (state_q == ASSERT);
  assign bus.irq_num = irq_num_q;
  assign bus.pend    = pend_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_intr_edge_arb.sv
// Randomized and directed bench for intr_edge_arb against a cycle-level
// behavioural model of pend/ovf/grant built from the event rules.
module tb_intr_edge_arb;
  localparam int N = 7;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  intr_edge_arb_if #(.NREQ(N), .IW(W)) bus ();
  intr_edge_arb #(.NREQ(N), .IW(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  bit [N-1:0] m_last, m_pend, m_ovf;
  bit         m_irq;
  int         m_num;

  task automatic model_reset();
    m_last = '0; m_pend = '0; m_ovf = '0; m_irq = 1'b0; m_num = 0;
  endtask

  task automatic drive_idle();
    bus.clken = 1'b1; bus.pol = '1; bus.enable = '1;
    bus.req_in = '0; bus.clr = '0; bus.irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: the model consumes the inputs currently driven, then the DUT clocks.
  task automatic step();
    bit [N-1:0] st, clrv, npend, novf;
    bit         nirq, e;
    int         nnum;
    for (int i = 0; i < N; i++) begin
      e = bus.clken && (bus.pol[i] ? (bus.req_in[i] && !m_last[i])
                                   : (!bus.req_in[i] && m_last[i]));
      st[i] = e && bus.enable[i];
    end
    clrv = bus.clr;
    nirq = m_irq;
    nnum = m_num;
    if (m_irq) begin
      if (bus.irq_ack) begin
        clrv[m_num] = 1'b1;
        nirq = 1'b0;
      end else if (!(m_pend[m_num] && bus.enable[m_num])) begin
        nirq = 1'b0;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && bus.enable[i]) begin nnum = i; nirq = 1'b1; end
    end
    for (int i = 0; i < N; i++) begin
      npend[i] = st[i] || (m_pend[i] && !clrv[i]);
      if (st[i] && m_pend[i] && !clrv[i]) novf[i] = 1'b1;
      else if (bus.clr[i] && !st[i])      novf[i] = 1'b0;
      else                                novf[i] = m_ovf[i];
    end
    @(posedge clk);
    if (bus.clken) m_last = bus.req_in;
    m_pend = npend; m_ovf = novf; m_irq = nirq; m_num = nnum;
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", bus.irq); else n_pass++;
    n_checks++; if (bus.irq_num !== 3'd0) $display("FAIL rst_num got %0d exp 0", bus.irq_num); else n_pass++;
    n_checks++; if (bus.pend !== 7'h00) $display("FAIL rst_pend got %h exp 00", bus.pend); else n_pass++;
    n_checks++; if (bus.ovf !== 7'h00) $display("FAIL rst_ovf got %h exp 00", bus.ovf); else n_pass++;
    do_reset();
  endtask

  task automatic test_rising_line3();
    do_reset();
    bus.req_in[3] = 1'b1;
    step();
    n_checks++; if (bus.pend !== 7'h08) $display("FAIL l3_pend got %h exp 08", bus.pend); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL l3_irq_early got %b exp 0", bus.irq); else n_pass++;
    step();
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL l3_irq got %b exp 1", bus.irq); else n_pass++;
    n_checks++; if (bus.irq_num !== 3'd3) $display("FAIL l3_num got %0d exp 3", bus.irq_num); else n_pass++;
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    n_checks++; if (bus.pend !== 7'h00) $display("FAIL l3_ack_pend got %h exp 00", bus.pend); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL l3_ack_irq got %b exp 0", bus.irq); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.req_in = 7'h24;
    step(); step();
    n_checks++; if (bus.irq_num !== 3'd2) $display("FAIL sc_first got %0d exp 2", bus.irq_num); else n_pass++;
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL sc_release got %b exp 0", bus.irq); else n_pass++;
    n_checks++; if (bus.pend !== 7'h20) $display("FAIL sc_pend got %h exp 20", bus.pend); else n_pass++;
    step();
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL sc_regrant got %b exp 1", bus.irq); else n_pass++;
    n_checks++; if (bus.irq_num !== 3'd5) $display("FAIL sc_second got %0d exp 5", bus.irq_num); else n_pass++;
  endtask

  task automatic test_hold_during_assert();
    do_reset();
    bus.req_in[4] = 1'b1;
    step(); step();
    bus.req_in[1] = 1'b1;
    step();
    n_checks++; if (bus.pend !== 7'h12) $display("FAIL hold_pend got %h exp 12", bus.pend); else n_pass++;
    step();
    n_checks++; if (bus.irq_num !== 3'd4) $display("FAIL hold_num got %0d exp 4", bus.irq_num); else n_pass++;
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL hold_release got %b exp 0", bus.irq); else n_pass++;
    step();
    n_checks++; if (bus.irq_num !== 3'd1 || bus.irq !== 1'b1)
      $display("FAIL hold_next got irq=%b num=%0d exp irq=1 num=1", bus.irq, bus.irq_num);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    bus.req_in[0] = 1'b1; step();
    bus.req_in[0] = 1'b0; step();
    bus.req_in[0] = 1'b1; step();
    n_checks++; if (bus.ovf[0] !== 1'b1) $display("FAIL ovr_set got %b exp 1", bus.ovf[0]); else n_pass++;
    bus.clr[0] = 1'b1; step(); bus.clr[0] = 1'b0;
    n_checks++; if (bus.pend[0] !== 1'b0 || bus.ovf[0] !== 1'b0)
      $display("FAIL ovr_clr got pend=%b ovf=%b exp 0 0", bus.pend[0], bus.ovf[0]);
    else n_pass++;
    bus.req_in[0] = 1'b0; step();
    bus.req_in[0] = 1'b1; step();
    bus.req_in[0] = 1'b0; step();
    bus.req_in[0] = 1'b1; step();
    bus.req_in[0] = 1'b0; step();
    bus.req_in[0] = 1'b1; bus.clr[0] = 1'b1; step(); bus.clr[0] = 1'b0;
    n_checks++; if (bus.pend[0] !== 1'b1 || bus.ovf[0] !== 1'b1)
      $display("FAIL ovr_setwins got pend=%b ovf=%b exp 1 1", bus.pend[0], bus.ovf[0]);
    else n_pass++;
  endtask

  task automatic test_falling_clken();
    do_reset();
    bus.pol = '0;
    bus.req_in = '1;
    for (int c = 0; c < 16; c++) begin
      bus.clken = (c % 4 == 0);
      if (c == 5)  bus.req_in[6] = 1'b0;
      if (c == 9)  bus.req_in[2] = 1'b0;
      if (c == 11) bus.req_in[2] = 1'b1;
      step();
      if (c == 7) begin
        n_checks++; if (bus.pend !== 7'h00) $display("FAIL fall_wait got %h exp 00", bus.pend); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (bus.pend !== 7'h40) $display("FAIL fall_cap got %h exp 40", bus.pend); else n_pass++;
      end
    end
    n_checks++; if (bus.pend !== 7'h40) $display("FAIL fall_short got %h exp 40", bus.pend); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bus.pol = N'($urandom);
    bus.enable = N'($urandom) | 7'h11;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.req_in ^= N'($urandom & $urandom);
      bus.clken = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) bus.clr[i] = ($urandom_range(0, 31) == 0);
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 63) == 0) bus.enable[$urandom_range(0, N - 1)] ^= 1'b1;
      step();
      n_checks++;
      if (bus.pend !== m_pend || bus.ovf !== m_ovf || bus.irq !== m_irq) begin
        if (bad < 10) $display("FAIL rnd_state c=%0d got pend=%h ovf=%h irq=%b exp pend=%h ovf=%h irq=%b",
                               c, bus.pend, bus.ovf, bus.irq, m_pend, m_ovf, m_irq);
        bad++;
      end else n_pass++;
      if (m_irq) begin
        n_checks++;
        if (bus.irq_num !== W'(m_num)) begin
          if (bad < 10) $display("FAIL rnd_num c=%0d got %0d exp %0d", c, bus.irq_num, m_num);
          bad++;
        end else n_pass++;
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_in[3] = 1'b1;
    step(); step();
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL ar_pre got %b exp 1", bus.irq); else n_pass++;
    #3 rst = 1'b1;
    bus.req_in = '0;
    model_reset();
    #1;
    n_checks++; if (bus.irq !== 1'b0 || bus.pend !== 7'h00)
      $display("FAIL ar_now got irq=%b pend=%h exp 0 00", bus.irq, bus.pend);
    else n_pass++;
    #1 rst = 1'b0;
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    step();
    n_checks++; if (bus.irq !== 1'b0 || bus.pend !== 7'h00)
      $display("FAIL ar_ack got irq=%b pend=%h exp 0 00", bus.irq, bus.pend);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rising_line3();
    test_same_cycle();
    test_hold_during_assert();
    test_overrun();
    test_falling_clken();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
